// File: rtl/snap_intr_pkg.sv
// Shared SNAP interrupt bridge types and defaults.
// State encoding plus default widths and timing parameters.
package snap_intr_pkg;

  localparam int SRC_W_DEF   = 64;
  localparam int CTX_W_DEF   = 9;
  localparam int GAP_DEF     = 4;
  localparam int TIMEOUT_DEF = 4096;
  localparam int RETRY_DEF   = 3;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ACKED = 3'd2,
    ST_GAP   = 3'd3,
    ST_DROP  = 3'd4
  } state_e;

endpackage

// File: rtl/axi_intr_host_bridge.sv
// Level interrupt to SNAP host-interrupt handshake bridge.
// Optional ack timeout/retry: define INTR_HOST_BRIDGE_TIMEOUT_EN.
module axi_intr_host_bridge
  import snap_intr_pkg::*;
#(
  parameter int SRC_WIDTH      = SRC_W_DEF,
  parameter int CTX_WIDTH      = CTX_W_DEF,
  parameter int GAP_CYCLES     = GAP_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int MAX_RETRY      = RETRY_DEF,
  parameter int CNT_WIDTH      = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  input  logic                 i_intr_level,
  output logic                 o_intr_ack,
  input  logic [SRC_WIDTH-1:0] i_cfg_src,
  input  logic [CTX_WIDTH-1:0] i_cfg_ctx,
  output logic                 o_interrupt,
  output logic [SRC_WIDTH-1:0] o_interrupt_src,
  output logic [CTX_WIDTH-1:0] o_interrupt_ctx,
  input  logic                 i_interrupt_ack,
  output logic [CNT_WIDTH-1:0] o_intr_count,
  output logic                 o_busy,
  output logic                 o_error
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_e               state_q, state_d;
  logic                 int_d;
  logic                 ack_d;
  logic [SRC_WIDTH-1:0] src_d;
  logic [CTX_WIDTH-1:0] ctx_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [GW-1:0]        gap_q, gap_d;

`ifdef INTR_HOST_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          err_d;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0) ^ (MAX_RETRY > 0);
`endif

  // Next-state and next-output logic for the handshake FSM
  always_comb begin
    state_d = state_q;
    int_d   = o_interrupt;
    ack_d   = 1'b0;
    src_d   = o_interrupt_src;
    ctx_d   = o_interrupt_ctx;
    cnt_d   = o_intr_count;
    gap_d   = gap_q;
`ifdef INTR_HOST_BRIDGE_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    retry_d = retry_q;
    err_d   = o_error;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (i_enable && i_intr_level) begin
          state_d = ST_REQ;
          int_d   = 1'b1;
          src_d   = i_cfg_src;
          ctx_d   = i_cfg_ctx;
`ifdef INTR_HOST_BRIDGE_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      ST_REQ: begin
        if (i_interrupt_ack) begin
          state_d = ST_ACKED;
          int_d   = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = o_intr_count + 1'b1;
`ifdef INTR_HOST_BRIDGE_TIMEOUT_EN
          tcnt_d  = '0;
          retry_d = '0;
`endif
        end
`ifdef INTR_HOST_BRIDGE_TIMEOUT_EN
        else if (!o_error) begin
          if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tcnt_d = '0;
            if (retry_q == RW'(MAX_RETRY)) begin
              err_d = 1'b1;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = ST_DROP;
              int_d   = 1'b0;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
`endif
      end
      ST_ACKED: begin
        state_d = ST_GAP;
        gap_d   = GW'(GAP_CYCLES - 1);
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
`ifdef INTR_HOST_BRIDGE_TIMEOUT_EN
      ST_DROP: begin
        state_d = ST_REQ;
        int_d   = 1'b1;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        int_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      o_interrupt     <= 1'b0;
      o_intr_ack      <= 1'b0;
      o_interrupt_src <= '0;
      o_interrupt_ctx <= '0;
      o_intr_count    <= '0;
      o_busy          <= 1'b0;
      gap_q           <= '0;
    end else begin
      state_q         <= state_d;
      o_interrupt     <= int_d;
      o_intr_ack      <= ack_d;
      o_interrupt_src <= src_d;
      o_interrupt_ctx <= ctx_d;
      o_intr_count    <= cnt_d;
      o_busy          <= (state_d != ST_IDLE);
      gap_q           <= gap_d;
    end
  end

`ifdef INTR_HOST_BRIDGE_TIMEOUT_EN
  // Timeout, retry and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q  <= '0;
      retry_q <= '0;
      o_error <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      retry_q <= retry_d;
      o_error <= err_d;
    end
  end
`else
  assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_axi_intr_host_bridge.sv
// Directed bench for axi_intr_host_bridge.
// Timeout checks run when INTR_HOST_BRIDGE_TIMEOUT_EN is defined.
module tb_axi_intr_host_bridge;

  localparam int SW = 64;
  localparam int CW = 9;
  localparam int NW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_enable;
  logic          i_intr_level;
  logic          o_intr_ack;
  logic [SW-1:0] i_cfg_src;
  logic [CW-1:0] i_cfg_ctx;
  logic          o_interrupt;
  logic [SW-1:0] o_interrupt_src;
  logic [CW-1:0] o_interrupt_ctx;
  logic          i_interrupt_ack;
  logic [NW-1:0] o_intr_count;
  logic          o_busy;
  logic          o_error;

  int n_chk = 0;
  int n_err = 0;

  axi_intr_host_bridge #(
    .SRC_WIDTH      (SW),
    .CTX_WIDTH      (CW),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (16),
    .MAX_RETRY      (2),
    .CNT_WIDTH      (NW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_enable        (i_enable),
    .i_intr_level    (i_intr_level),
    .o_intr_ack      (o_intr_ack),
    .i_cfg_src       (i_cfg_src),
    .i_cfg_ctx       (i_cfg_ctx),
    .o_interrupt     (o_interrupt),
    .o_interrupt_src (o_interrupt_src),
    .o_interrupt_ctx (o_interrupt_ctx),
    .i_interrupt_ack (i_interrupt_ack),
    .o_intr_count    (o_intr_count),
    .o_busy          (o_busy),
    .o_error         (o_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_int(input string tag);
    int n = 0;
    while (!o_interrupt && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 64'(o_interrupt), 64'd1);
  endtask

  task automatic serve(input string tag);
    wait_int(tag);
    i_interrupt_ack = 1'b1;
    tick();
    i_interrupt_ack = 1'b0;
    chk(tag, 64'(o_intr_ack), 64'd1);
  endtask

  initial begin
    int n;
    int acks;
    int drops;
    logic ok;

    rst_n           = 1'b0;
    i_enable        = 1'b0;
    i_intr_level    = 1'b0;
    i_cfg_src       = '0;
    i_cfg_ctx       = '0;
    i_interrupt_ack = 1'b0;
    #12;
    chk("rst_int", 64'(o_interrupt), 64'd0);
    chk("rst_ack", 64'(o_intr_ack), 64'd0);
    chk("rst_src", o_interrupt_src, 64'd0);
    chk("rst_ctx", 64'(o_interrupt_ctx), 64'd0);
    chk("rst_cnt", 64'(o_intr_count), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_err", 64'(o_error), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // basic request, 1-cycle latency, frozen src/ctx
    i_enable     = 1'b1;
    i_intr_level = 1'b1;
    i_cfg_src    = 64'h1234;
    i_cfg_ctx    = 9'd5;
    tick();
    chk("t1_raise", 64'(o_interrupt), 64'd1);
    chk("t1_src", o_interrupt_src, 64'h1234);
    chk("t1_ctx", 64'(o_interrupt_ctx), 64'd5);
    chk("t1_busy", 64'(o_busy), 64'd1);
    i_cfg_src = 64'hdead_beef;
    i_cfg_ctx = 9'h1ff;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!o_interrupt || o_intr_ack ||
          o_interrupt_src != 64'h1234 ||
          o_interrupt_ctx != 9'd5)
        ok = 1'b0;
    end
    chk("t1_hold", 64'(ok), 64'd1);
    i_interrupt_ack = 1'b1;
    tick();
    i_interrupt_ack = 1'b0;
    chk("t1_drop", 64'(o_interrupt), 64'd0);
    chk("t1_ack", 64'(o_intr_ack), 64'd1);
    chk("t1_cnt", 64'(o_intr_count), 64'd1);

    // gap: ACKED + 4 GAP cycles low, then IDLE re-raises
    n    = 0;
    acks = 0;
    while (n < 20) begin
      tick();
      if (o_interrupt) break;
      if (o_intr_ack) acks++;
      i_interrupt_ack = (n == 2);
      n++;
    end
    chk("t2_gap", 64'(n), 64'd5);
    chk("t2_stray", 64'(acks), 64'd0);
    chk("t2_cnt", 64'(o_intr_count), 64'd1);
    chk("t2_src", o_interrupt_src, 64'hdead_beef);
    chk("t2_ctx", 64'(o_interrupt_ctx), 64'h1ff);
    i_enable     = 1'b0;
    i_intr_level = 1'b0;
    repeat (3) tick();
    chk("t2_hold", 64'(o_interrupt), 64'd1);
    i_interrupt_ack = 1'b1;
    tick();
    i_interrupt_ack = 1'b0;
    chk("t2_ack", 64'(o_intr_ack), 64'd1);
    chk("t2_cnt2", 64'(o_intr_count), 64'd2);

    // enable gating in IDLE, stray ack in IDLE
    i_intr_level = 1'b1;
    repeat (10) tick();
    chk("t3_off", 64'(o_interrupt), 64'd0);
    chk("t3_idle", 64'(o_busy), 64'd0);
    i_interrupt_ack = 1'b1;
    tick();
    i_interrupt_ack = 1'b0;
    chk("t3_stray", 64'(o_intr_ack), 64'd0);
    chk("t3_cnt", 64'(o_intr_count), 64'd2);
    i_enable = 1'b1;
    tick();
    chk("t3_raise", 64'(o_interrupt), 64'd1);
    i_interrupt_ack = 1'b1;
    tick();
    i_interrupt_ack = 1'b0;
    chk("t3_cnt2", 64'(o_intr_count), 64'd3);

`ifdef INTR_HOST_BRIDGE_TIMEOUT_EN
    // 16-cycle timeout, two drops, then sticky error
    wait_int("t5_raise");
    drops = 0;
    n     = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (!o_interrupt) begin
        drops++;
        if (n < 0) n = i;
      end
    end
    chk("t5_first", 64'(n), 64'd16);
    chk("t5_drops", 64'(drops), 64'd2);
    chk("t5_err", 64'(o_error), 64'd1);
    chk("t5_int", 64'(o_interrupt), 64'd1);
    i_interrupt_ack = 1'b1;
    tick();
    i_interrupt_ack = 1'b0;
    chk("t5_ack", 64'(o_intr_ack), 64'd1);
    tick();
    chk("t5_sticky", 64'(o_error), 64'd1);
`else
    // no timeout: request waits indefinitely
    wait_int("t5_raise");
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!o_interrupt || o_error) ok = 1'b0;
    end
    chk("t5_wait", 64'(ok), 64'd1);
    i_interrupt_ack = 1'b1;
    tick();
    i_interrupt_ack = 1'b0;
    chk("t5_ack", 64'(o_intr_ack), 64'd1);
    chk("t5_err", 64'(o_error), 64'd0);
`endif
    chk("t5_cnt", 64'(o_intr_count), 64'd4);

    // counter wrap on a 3-bit counter
    serve("w5");
    serve("w6");
    serve("w7");
    chk("wrap_7", 64'(o_intr_count), 64'd7);
    serve("w8");
    chk("wrap_0", 64'(o_intr_count), 64'd0);
    serve("w9");
    chk("wrap_1", 64'(o_intr_count), 64'd1);

    // async reset in REQ
    wait_int("t6_raise");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_int", 64'(o_interrupt), 64'd0);
    chk("t6_busy", 64'(o_busy), 64'd0);
    chk("t6_cnt", 64'(o_intr_count), 64'd0);
    i_intr_level = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("t6_idle", 64'(o_busy), 64'd0);
    chk("t6_cnt2", 64'(o_intr_count), 64'd0);
    chk("t6_int2", 64'(o_interrupt), 64'd0);
    chk("t6_err", 64'(o_error), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
